// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory load/store initiator.
package dmem_pkg;

  // Access size encodings carried on req_size.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Initiator control states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  // True when the access cannot be performed at this alignment.
  // The illegal size encoding is folded in so one check covers both.
  function automatic logic access_misaligned(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
    logic bad_s;
    case (size)
      SZ_BYTE: bad_s = 1'b0;
      SZ_HALF: bad_s = addr_lo[0];
      SZ_WORD: bad_s = (addr_lo != 2'b00);
      default: bad_s = 1'b1;
    endcase
    return bad_s;
  endfunction

endpackage

// File: rtl/dmem_initiator_lane_align.sv
// Byte/halfword lane handling: merges store data into the current memory
// word and extracts/extends load data from it.
module mem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_word,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed lane, extend it for loads and splice it for stores.
  always_comb begin
    byte_s      = 8'h00;
    half_s      = 16'h0000;
    merged_word = mem_word;
    load_data   = 32'h0000_0000;
    case (addr_lo)
      2'b00:   byte_s = mem_word[7:0];
      2'b01:   byte_s = mem_word[15:8];
      2'b10:   byte_s = mem_word[23:16];
      2'b11:   byte_s = mem_word[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    case (size)
      SZ_BYTE: begin
        load_data = is_unsigned ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
        case (addr_lo)
          2'b00:   merged_word[7:0]   = store_data[7:0];
          2'b01:   merged_word[15:8]  = store_data[7:0];
          2'b10:   merged_word[23:16] = store_data[7:0];
          2'b11:   merged_word[31:24] = store_data[7:0];
          default: merged_word        = mem_word;
        endcase
      end
      SZ_HALF: begin
        load_data = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
        if (addr_lo[1]) begin
          merged_word[31:16] = store_data[15:0];
        end else begin
          merged_word[15:0] = store_data[15:0];
        end
      end
      SZ_WORD: begin
        load_data   = mem_word;
        merged_word = store_data;
      end
      default: begin
        load_data   = 32'h0000_0000;
        merged_word = mem_word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_initiator.sv
// Single-outstanding load/store initiator in front of a word-only data
// memory. Sub-word stores are read-modify-write using the memory's
// combinational read and clocked write.
module dmem_initiator
  import dmem_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int MEM_WORDS   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0]  WAIT_LAST  = 4'(WAIT_STATES);
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  cnt_r;
  logic        write_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_error_r;
  logic        accept_s;
  logic        req_err_s;
  logic        final_s;
  logic [31:0] merged_s;
  logic [31:0] load_s;

  assign accept_s  = req_valid & req_ready;
  // Range check is done one bit wider so addresses near 2^32 cannot wrap.
  assign req_err_s = access_misaligned(req_size, req_addr[1:0]) |
                     ({1'b0, req_addr} >= ADDR_LIMIT);
  assign final_s   = (state_r == ACCESS) && (cnt_r == WAIT_LAST);
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_error = rsp_error_r;

  mem_lane_align u_lane (
    .size        (size_r),
    .is_unsigned (unsigned_r),
    .addr_lo     (addr_r[1:0]),
    .store_data  (wdata_r),
    .mem_word    (mem_rdata),
    .merged_word (merged_s),
    .load_data   (load_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and memory/handshake outputs.
  always_comb begin
    state_next_s = state_r;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    mem_address  = 32'h0000_0000;
    mem_wdata    = 32'h0000_0000;
    mem_we       = 1'b0;
    case (state_r)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next_s = req_err_s ? RESP : ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        mem_address = {addr_r[31:2], 2'b00};
        if (final_s) begin
          state_next_s = RESP;
          if (write_r) begin
            // Gate with reset so no write lands on a resetting edge.
            mem_we    = reset;
            mem_wdata = merged_s;
          end else begin
            mem_we    = 1'b0;
            mem_wdata = 32'h0000_0000;
          end
        end else begin
          state_next_s = ACCESS;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Request capture, wait counter and response data registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r       <= 4'd0;
      write_r     <= 1'b0;
      size_r      <= 2'b00;
      unsigned_r  <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_error_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            write_r     <= req_write;
            size_r      <= req_size;
            unsigned_r  <= req_unsigned;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            cnt_r       <= 4'd0;
            rsp_error_r <= req_err_s;
            rsp_rdata_r <= 32'h0000_0000;
          end
        end
        ACCESS: begin
          // Counter stops at the final cycle, so it never wraps.
          if (!final_s) begin
            cnt_r <= cnt_r + 4'd1;
          end else if (!write_r) begin
            rsp_rdata_r <= load_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_initiator.sv
// Bench for dmem_initiator: two instances (0 and 2 wait states), each with
// its own word memory, checked against a byte-level reference model.
module tb_dmem_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  reset, req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  rsp_valid, rsp_ready, rsp_error, mem_we;
  logic [1:0]  req_size    [2];
  logic [31:0] req_addr    [2];
  logic [31:0] req_wdata   [2];
  logic [31:0] rsp_rdata   [2];
  logic [31:0] mem_address [2];
  logic [31:0] mem_wdata   [2];
  logic [31:0] mem_rdata   [2];

  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  logic [31:0] ref_mem [2][64];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data0, pl_data1;

  int n_vec = 0;
  int n_bad = 0;

  dmem_initiator #(.WAIT_STATES(0), .MEM_WORDS(64)) u_dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]),
    .mem_address(mem_address[0]), .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]),
    .mem_rdata(mem_rdata[0])
  );

  dmem_initiator #(.WAIT_STATES(2), .MEM_WORDS(64)) u_dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]),
    .mem_address(mem_address[1]), .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]),
    .mem_rdata(mem_rdata[1])
  );

  // Word memories: combinational read, clocked write (or preload).
  assign mem_rdata[0] = mem0[mem_address[0][7:2]];
  assign mem_rdata[1] = mem1[mem_address[1][7:2]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem0[pl_idx] <= pl_data0;
      mem1[pl_idx] <= pl_data1;
    end else begin
      if (mem_we[0]) mem0[mem_address[0][7:2]] <= mem_wdata[0];
      if (mem_we[1]) mem1[mem_address[1][7:2]] <= mem_wdata[1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: is the request rejected?
  function automatic logic ref_err(input int sz, input logic [31:0] a);
    return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0) || (a >= 32'd256);
  endfunction

  // Reference: load value from a word, treated as plain numbers.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int sz, input logic uns, input int lane);
    logic [31:0] v;
    if (sz == 0) begin
      v = (w >> (8 * lane)) & 32'd255;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 1) begin
      v = (w >> (16 * (lane / 2))) & 32'd65535;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Reference: store into a word viewed as four bytes.
  function automatic logic [31:0] ref_store(input logic [31:0] w, input int sz, input int lane, input logic [31:0] wd);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = 8'(w >> (8 * i));
    if (sz == 0) begin
      b[lane] = 8'(wd);
    end else if (sz == 1) begin
      b[lane]     = 8'(wd);
      b[lane + 1] = 8'(wd >> 8);
    end else begin
      for (int i = 0; i < 4; i++) b[i] = 8'(wd >> (8 * i));
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // One complete transaction on instance d, checked cycle by cycle.
  task automatic txn(input int d, input logic wr, input int sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input int hold,
                     output logic [31:0] rd);
    int ws, we_cnt, lat;
    logic err;
    logic [31:0] exp_rd, exp_word;
    string p;
    ws = (d == 0) ? 0 : 2;
    err = ref_err(sz, a);
    we_cnt = 0;
    lat = 0;
    exp_rd = 32'd0;
    exp_word = 32'd0;
    p = $sformatf("d%0d %s sz%0d a=%0h", d, wr ? "st" : "ld", sz, a);
    if (!err && !wr) exp_rd = ref_load(ref_mem[d][a / 4], sz, uns, int'(a % 4));
    if (!err && wr) exp_word = ref_store(ref_mem[d][a / 4], sz, int'(a % 4), wd);
    @(negedge clk);
    chk({p, " req_ready"}, {31'd0, req_ready[d]}, 32'd1);
    req_valid[d] = 1'b1; req_write[d] = wr; req_size[d] = 2'(sz);
    req_unsigned[d] = uns; req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      req_valid[d] = 1'b0;
      if (mem_we[d]) begin
        we_cnt++;
        chk({p, " we_addr"}, mem_address[d], {a[31:2], 2'b00});
        chk({p, " we_data"}, mem_wdata[d], exp_word);
      end
      if (rsp_valid[d]) lat = k;
      else if (!err) chk({p, " mem_address"}, mem_address[d], {a[31:2], 2'b00});
    end
    chk({p, " latency"}, lat, err ? 32'd1 : 32'(ws + 2));
    chk({p, " we_pulses"}, we_cnt, (wr && !err) ? 32'd1 : 32'd0);
    chk({p, " rsp_error"}, {31'd0, rsp_error[d]}, {31'd0, err});
    chk({p, " rsp_rdata"}, rsp_rdata[d], exp_rd);
    rd = rsp_rdata[d];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({p, " hold valid"}, {31'd0, rsp_valid[d]}, 32'd1);
      chk({p, " hold rdata"}, rsp_rdata[d], exp_rd);
      chk({p, " hold req_ready"}, {31'd0, req_ready[d]}, 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk({p, " after rsp_valid"}, {31'd0, rsp_valid[d]}, 32'd0);
    if (!err && wr) ref_mem[d][a / 4] = exp_word;
  endtask

  logic [31:0] rd;

  initial begin
    reset = 2'b00; req_valid = 2'b00; rsp_ready = 2'b00;
    req_write = 2'b00; req_unsigned = 2'b00;
    for (int d = 0; d < 2; d++) begin
      req_size[d] = 2'b00; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end
    pl_en = 1'b1; pl_idx = 6'd0; pl_data0 = 32'd0; pl_data1 = 32'd0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pl_idx = 6'(i);
      pl_data0 = (i == 1) ? 32'h8899AABB : $urandom;
      pl_data1 = (i == 1) ? 32'h8899AABB : $urandom;
      ref_mem[0][i] = pl_data0;
      ref_mem[1][i] = pl_data1;
    end
    @(negedge clk);
    pl_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset d%0d req_ready", d), {31'd0, req_ready[d]}, 32'd1);
      chk($sformatf("reset d%0d rsp_valid", d), {31'd0, rsp_valid[d]}, 32'd0);
      chk($sformatf("reset d%0d rsp_rdata", d), rsp_rdata[d], 32'd0);
      chk($sformatf("reset d%0d rsp_error", d), {31'd0, rsp_error[d]}, 32'd0);
      chk($sformatf("reset d%0d mem_address", d), mem_address[d], 32'd0);
      chk($sformatf("reset d%0d mem_we", d), {31'd0, mem_we[d]}, 32'd0);
    end
    reset = 2'b11;

    // Directed loads/stores, zero wait states.
    txn(0, 1'b0, 2, 1'b0, 32'h4, 32'd0, 0, rd); chk("lw 0x4", rd, 32'h8899AABB);
    txn(0, 1'b0, 0, 1'b0, 32'h5, 32'd0, 0, rd); chk("lb 0x5", rd, 32'hFFFFFFAA);
    txn(0, 1'b0, 0, 1'b1, 32'h5, 32'd0, 0, rd); chk("lbu 0x5", rd, 32'h000000AA);
    txn(0, 1'b0, 1, 1'b0, 32'h6, 32'd0, 0, rd); chk("lh 0x6", rd, 32'hFFFF8899);
    txn(0, 1'b0, 1, 1'b1, 32'h6, 32'd0, 0, rd); chk("lhu 0x6", rd, 32'h00008899);
    txn(0, 1'b1, 0, 1'b0, 32'h6, 32'h12345677, 0, rd);
    chk("sb 0x6 memory", mem0[1], 32'h8877AABB);
    txn(0, 1'b0, 2, 1'b0, 32'h4, 32'd0, 0, rd); chk("lw after sb", rd, 32'h8877AABB);
    txn(0, 1'b0, 2, 1'b0, 32'h6, 32'd0, 0, rd);
    txn(0, 1'b1, 1, 1'b0, 32'h5, 32'hFFFF, 0, rd);
    txn(0, 1'b0, 2, 1'b0, 32'h100, 32'd0, 0, rd);
    txn(0, 1'b0, 3, 1'b0, 32'h8, 32'd0, 1, rd);

    // Two wait states with a stalled consumer.
    txn(1, 1'b0, 2, 1'b0, 32'h4, 32'd0, 3, rd); chk("ws2 lw 0x4", rd, 32'h8899AABB);

    // Reset in the second ACCESS cycle of a store aborts it.
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_size[1] = 2'b10;
    req_unsigned[1] = 1'b0; req_addr[1] = 32'h4; req_wdata[1] = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("abort access1 addr", mem_address[1], 32'h4);
    chk("abort access1 we", {31'd0, mem_we[1]}, 32'd0);
    @(negedge clk);
    chk("abort access2 we", {31'd0, mem_we[1]}, 32'd0);
    reset[1] = 1'b0;
    @(negedge clk);
    reset[1] = 1'b1;
    chk("abort req_ready", {31'd0, req_ready[1]}, 32'd1);
    chk("abort rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
    chk("abort mem_address", mem_address[1], 32'd0);
    chk("abort mem_we", {31'd0, mem_we[1]}, 32'd0);
    @(negedge clk);
    chk("abort rsp_valid later", {31'd0, rsp_valid[1]}, 32'd0);
    chk("abort word1", mem1[1], 32'h8899AABB);

    // Randomized traffic on both instances.
    for (int i = 0; i < 80; i++) begin
      int d, sz, sel;
      logic [31:0] a;
      d = i % 2;
      sz = $urandom_range(0, 9);
      sz = (sz > 3) ? (sz % 3) : sz;
      sel = $urandom_range(0, 9);
      a = (sel == 0) ? $urandom : (sel == 1) ? 32'($urandom_range(256, 300)) : 32'($urandom_range(0, 255));
      txn(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
          $urandom_range(0, 2), rd);
    end

    for (int i = 0; i < 64; i++) begin
      chk($sformatf("final mem0[%0d]", i), mem0[i], ref_mem[0][i]);
      chk($sformatf("final mem1[%0d]", i), mem1[i], ref_mem[1][i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_initiator.md
Name: dmem_initiator

Overview:
- Load/store initiator that sits between the processor's memory-request side and the word-only data_mem.
- Accepts byte, halfword and word loads and stores through a valid/ready request and a valid/ready response.
- Drives word-aligned address, write data and write enable to data_mem. Sub-word stores are done as read-modify-write, using data_mem's combinational read and clocked write.
- Has optional wait states for slower memories, plus misalignment and range checking.

Parameters:
- WAIT_STATES, 0: extra cycles the memory address is held before the access completes (0..15).
- MEM_WORDS, 64: number of words in the target memory. Byte addresses at or above 4*MEM_WORDS are out of range.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-low reset; sampled at posedge clk.
- req_valid  input  1  request present.
- req_ready  output  1  initiator can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = halfword, 10 = word; 11 is illegal.
- req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (the byte or halfword sits in the low bits).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_error  output  1  misaligned, out-of-range or illegal size.
- mem_address  output  32  word-aligned address to data_mem: {addr[31:2], 2'b00}.
- mem_wdata  output  32  merged full word to data_mem.
- mem_we  output  1  data_mem write enable.
- mem_rdata  input  32  data_mem combinational read data.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Only IDLE asserts req_ready.
- IDLE:
  - On req_valid & req_ready, latch write, size, unsigned, addr and wdata.
  - Error condition: size==11, half with addr[0]=1, word with addr[1:0]!=0, or addr >= 4*MEM_WORDS.
  - If error: go to RESP with rsp_error=1. No memory access is made and mem_we is never asserted.
  - Otherwise: go to ACCESS and clear the wait counter.
- ACCESS:
  - mem_address is driven from the latched address and held stable for WAIT_STATES+1 cycles.
  - The wait counter increments each cycle. The final cycle is the one where counter == WAIT_STATES.
  - Load: on the posedge ending the final cycle, capture the extracted, extended lane from mem_rdata into rsp_rdata.
  - Store: mem_we=1 only in the final cycle, for exactly one cycle.
  - mem_wdata = mem_rdata with the addressed byte/half lane replaced by the low bits of wdata. A word store replaces all four lanes.
  - Exit to RESP after the final cycle.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_error are held stable until rsp_ready=1 at a posedge, then go to IDLE.
  - No new request is accepted in RESP; this is a single-outstanding design.
- Latency with WAIT_STATES=0: request accepted at edge N; ACCESS during cycle N+1; rsp_valid during cycle N+2; earliest next accept at N+3. Each wait state adds 1 cycle.
- Error latency: rsp_valid in the cycle after accept.
- Lane extract:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Sign-extend from bit 7 (byte) or bit 15 (half) unless unsigned. Word loads are never extended.
- Outside the final ACCESS cycle of a store: mem_we=0 and mem_wdata=0. mem_address is 0 outside ACCESS.
- Reset (reset==0 at posedge):
  - state=IDLE; counter=0; all latched fields=0.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0, req_ready=1 after the edge. mem_address=0, mem_we=0.
- mem_we is gated by reset: mem_we = store_final & reset. No write lands on an edge where reset is low.
- Reset mid-ACCESS aborts the transaction and drops its response; memory is unchanged if the write cycle was not reached.
- Counter width is 4 bits; it saturates at WAIT_STATES and never wraps.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state enum {IDLE, ACCESS, RESP}.
  - Misalignment check function.
- One combinational sub-module, mem_lane_align:
  - inputs: size, unsigned, addr[1:0], store data, memory word.
  - outputs: merged store word and extended load data.
  - The FSM lives in dmem_initiator.

Test Plan:
- Preload word 1 = 0x8899AABB. lw addr 0x4, WAIT_STATES=0, rsp_ready=1 -> rsp_valid two cycles after accept, rsp_rdata=0x8899AABB, rsp_error=0, mem_we never 1.
- lb 0x5 -> 0xFFFFFFAA. lbu 0x5 -> 0x000000AA. lh 0x6 -> 0xFFFF8899. lhu 0x6 -> 0x00008899.
- sb 0x6 with wdata 0x12345677 -> mem_we high for exactly one cycle, mem_address=0x4, mem_wdata=0x8877AABB. A following lw 0x4 -> 0x8877AABB.
- lw 0x6 and sh 0x5 each -> rsp_error=1 one cycle after accept, rsp_rdata=0, mem_we never asserted. lw 0x100 with MEM_WORDS=64 -> rsp_error=1.
- WAIT_STATES=2: lw 0x4 -> mem_address=0x4 for 3 cycles, rsp_valid at accept+4. Hold rsp_ready=0 for 3 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout.
- sw 0x4 wdata 0xDEADBEEF, WAIT_STATES=2, reset=0 in the second ACCESS cycle -> no mem_we pulse, word 1 still 0x8899AABB. After reset: req_ready=1, rsp_valid=0.
